ahb_master: RTL

Single-clock AHB-Lite initiator that converts simple command requests into pipelined AHB transfers. It drives HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA toward the AHB-to-APB bridge slave, honours HREADY wait states and HRESP errors, and returns read data to the requesting logic. It is the traffic source for bridge-level simulation and the bus front end for on-chip command engines.

---
 rtl/ahb_master.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ahb_master.sv
// rtl/ahb_master.sv - AHB-Lite initiator turning single/INCR4 commands into pipelined bus transfers
//
// Ports:
//   HCLK, HRESETn          bus clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only while idle)
//   cmd_write, cmd_burst   direction (1 = write) and length (0 = SINGLE, 1 = INCR4)
//   cmd_addr               start address, word aligned internally
//   wr_data, wr_pop        write word source; wr_pop marks the word taken this cycle
//   rd_data, rd_valid      captured read word with a one-cycle strobe per beat
//   done, err              one-cycle completion strobe, err set when the slave answered ERROR
//   HADDR..HWDATA          registered AHB-Lite master outputs
//   HREADYin, HRDATA, HRESP  AHB-Lite slave response
`timescale 1ns/1ps

module ahb_master (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_burst,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] wr_data,
  output logic        wr_pop,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic        HREADYin,
  input  logic [31:0] HRDATA,
  input  logic [1:0]  HRESP
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [1:0]  state;
  logic [1:0]  beat;
  logic        burst;
  logic        dp_active;
  logic        last_beat;
  logic        resp_err;
  logic        rd_capture;
  logic [31:0] next_addr;

  // A data phase is in flight whenever a previous address phase has completed:
  // every ADDR beat after the first, and the whole of LAST.
  assign dp_active  = ((state == S_ADDR) && (beat != 2'd0)) || (state == S_LAST);
  assign last_beat  = !burst || (beat == 2'd3);
  assign resp_err   = (HRESP == 2'b01);
  assign rd_capture = dp_active && !HWRITE && HREADYin && !resp_err;
  assign next_addr  = HADDR + 32'd4;

  assign cmd_ready = (state == S_IDLE);
  assign HSIZE     = 3'b010;

  // The word is consumed at the same edge that loads it into HWDATA, so the
  // source can advance wr_data on that edge and the next beat sees a fresh word.
  assign wr_pop = (state == S_ADDR) && HWRITE && HREADYin;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      beat     <= 2'd0;
      burst    <= 1'b0;
      HADDR    <= 32'd0;
      HTRANS   <= TR_IDLE;
      HWRITE   <= 1'b0;
      HBURST   <= 3'b000;
      HWDATA   <= 32'd0;
      rd_data  <= 32'd0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;

      if (rd_capture) begin
        rd_data  <= HRDATA;
        rd_valid <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            state  <= S_ADDR;
            beat   <= 2'd0;
            burst  <= cmd_burst;
            HADDR  <= {cmd_addr[31:2], 2'b00};
            HTRANS <= TR_NONSEQ;
            HWRITE <= cmd_write;
            HBURST <= cmd_burst ? 3'b011 : 3'b000;
          end
        end

        S_ADDR: begin
          if (HREADYin) begin
            if (HWRITE) begin
              HWDATA <= wr_data;
            end
            if (last_beat) begin
              state  <= S_LAST;
              HTRANS <= TR_IDLE;
            end else begin
              beat  <= beat + 2'd1;
              HADDR <= next_addr;
              // A beat starting a new 1 KB page restarts the burst as NONSEQ.
              HTRANS <= (next_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
            end
          end else if (dp_active && resp_err) begin
            // First error cycle: cancel the pending address phase.
            state  <= S_ERR;
            HTRANS <= TR_IDLE;
          end
        end

        S_LAST: begin
          if (HREADYin) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else if (resp_err) begin
            state <= S_ERR;
          end
        end

        default: begin
          if (HREADYin) begin
            state <= S_IDLE;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
